// File: rtl/ntt_layer_sched_if.sv
// Butterfly-side bus of the NTT layer scheduler: issue handshake, coefficient
// indices, zeta ROM lookup and the writeback-complete strobe.
interface ntt_layer_sched_if #(
    parameter int W = 16
);
    logic         bf_valid;
    logic         bf_ready;
    logic [7:0]   left_idx_o;
    logic [7:0]   right_idx_o;
    logic [6:0]   zeta_addr_o;
    logic [W-1:0] zeta_data_i;
    logic [W-1:0] twiddle_o;
    logic         out_valid_i;

    modport master (
        output bf_valid, left_idx_o, right_idx_o, zeta_addr_o, twiddle_o,
        input  bf_ready, zeta_data_i, out_valid_i
    );

    modport slave (
        input  bf_valid, left_idx_o, right_idx_o, zeta_addr_o, twiddle_o,
        output bf_ready, zeta_data_i, out_valid_i
    );
endinterface

// File: rtl/ntt_layer_sched.sv
// Constant-time issue scheduler for a 256-point forward NTT: walks 7 layers of
// 128 butterflies each, tracking in-flight butterflies between layers.
module ntt_layer_sched #(
    parameter int N_COEFF = 256,
    parameter int W       = 16,
    parameter int INFL_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    ntt_layer_sched_if.master     bf,
    output logic                  busy,
    output logic [2:0]            layer_o,
    output logic                  done,
    output logic                  aborted,
    output logic [15:0]           cycles_o
);
    localparam logic [6:0] LAST_B = 7'(N_COEFF / 2 - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, ABORT, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        layer_q, layer_d;
    logic [6:0]        b_q, b_d;
    logic [INFL_W-1:0] infl_q, infl_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       cyc_q, cyc_d;

    logic              hs;
    logic              infl_zero;
    logic [2:0]        shamt;
    logic [7:0]        len;
    logic [6:0]        g;
    logic [7:0]        off;
    logic [7:0]        left;
    logic [6:0]        zeta;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Index generation is a pure function of (layer, b), so timing never depends on data.
    always_comb begin
        shamt = 3'd7 - layer_q;
        len   = 8'd1 << shamt;
        g     = b_q >> shamt;
        off   = {1'b0, b_q} & (len - 8'd1);
        left  = ({g, 1'b0} << shamt) + off;
        zeta  = (7'd1 << layer_q) + g;
    end

    assign hs        = (state_q == ISSUE) && bf.bf_ready;
    assign infl_zero = (infl_q == '0);

    assign bf.bf_valid    = (state_q == ISSUE);
    assign bf.left_idx_o  = (state_q == ISSUE) ? left : 8'd0;
    assign bf.right_idx_o = (state_q == ISSUE) ? left + len : 8'd0;
    assign bf.zeta_addr_o = (state_q == ISSUE) ? zeta : 7'd0;
    assign bf.twiddle_o   = bf.zeta_data_i;

    assign busy     = (state_q != IDLE);
    assign layer_o  = layer_q;
    assign done     = (state_q == DONE);
    assign aborted  = (state_q == ABORT) && infl_zero;
    assign cycles_o = cyc_q;

    always_comb begin
        infl_d = infl_q;
        if (hs && !bf.out_valid_i)
            infl_d = infl_q + INFL_W'(1);
        else if (!hs && bf.out_valid_i && !infl_zero)
            infl_d = infl_q - INFL_W'(1);
    end

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        b_d     = b_q;
        cyc_d   = cyc_q;
        cnt_d   = (state_q != IDLE) ? sat_inc16(cnt_q) : cnt_q;
        if (hs)
            b_d = b_q + 7'd1;
        case (state_q)
            IDLE: begin
                if (start) begin
                    layer_d = 3'd0;
                    b_d     = 7'd0;
                    cnt_d   = 16'd0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (abort)
                    state_d = ABORT;
                else if (hs && b_q == LAST_B)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (abort)
                    state_d = ABORT;
                else if (infl_zero) begin
                    if (layer_q < 3'd6) begin
                        layer_d = layer_q + 3'd1;
                        state_d = ISSUE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ABORT: begin
                if (infl_zero) begin
                    cyc_d   = sat_inc16(cnt_q);
                    state_d = IDLE;
                end
            end
            DONE: begin
                cyc_d   = sat_inc16(cnt_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            layer_q <= 3'd0;
            b_q     <= 7'd0;
            infl_q  <= '0;
            cnt_q   <= 16'd0;
            cyc_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            b_q     <= b_d;
            infl_q  <= infl_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
        end
    end
endmodule

// File: tb/tb_ntt_layer_sched.sv
// Scoreboard bench for ntt_layer_sched: expected butterfly pairs come from the
// textbook Cooley-Tukey loop nest; a fixed-latency butterfly stub closes the loop.
module tb_ntt_layer_sched;
    typedef struct {int l; int r; int z;} pair_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy, done, aborted;
    logic [2:0]  layer;
    logic [15:0] cycles;

    ntt_layer_sched_if #(.W(16)) bus ();

    ntt_layer_sched #(.N_COEFF(256), .W(16), .INFL_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bf(bus.master),
        .busy(busy), .layer_o(layer), .done(done), .aborted(aborted), .cycles_o(cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom(input logic [6:0] a);
        return {a, ~a, 2'b01};
    endfunction

    assign bus.zeta_data_i = rom(bus.zeta_addr_o);

    pair_t sb[$];
    int    due[$];
    int    cyc = 0, lat = 4, ready_mode = 0;
    int    hs_idx = 0, m_inf = 0, done_cnt = 0, abort_cnt = 0;
    int    n_checks = 0, n_pass = 0;
    logic  prev_stall = 1'b0;
    logic [7:0] held_l, held_r;
    logic [6:0] held_z;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: classic forward-NTT loop nest, zeta index running 1..127.
    task automatic load_expected();
        int k;
        sb.delete();
        k = 1;
        for (int ln = 128; ln >= 2; ln = ln / 2) begin
            for (int st = 0; st < 256; st += 2 * ln) begin
                for (int j = st; j < st + ln; j++) sb.push_back('{j, j + ln, k});
                k++;
            end
        end
    endtask

    // Stimulus for bf_ready and the butterfly-stub writeback strobe.
    always @(posedge clk) begin
        #1;
        cyc++;
        case (ready_mode)
            0: bus.bf_ready = 1'b1;
            1: bus.bf_ready = ~bus.bf_ready;
            default: bus.bf_ready = 1'($urandom_range(0, 1));
        endcase
        bus.out_valid_i = (due.size() > 0 && due[0] == cyc);
        if (bus.out_valid_i) void'(due.pop_front());
    end

    // Monitor: pops the scoreboard on every handshake.
    always @(negedge clk) begin
        logic  hs;
        pair_t e;
        hs = bus.bf_valid && bus.bf_ready;
        if (rst_n) begin
            if (hs) begin
                if (sb.size() == 0) fail_now("unexpected_issue");
                else begin
                    e = sb.pop_front();
                    check("left_idx", int'(bus.left_idx_o), e.l);
                    check("right_idx", int'(bus.right_idx_o), e.r);
                    check("zeta_addr", int'(bus.zeta_addr_o), e.z);
                    check("twiddle", int'(bus.twiddle_o), int'(rom(7'(e.z))));
                    check("layer_o", int'(layer), hs_idx / 128);
                end
                if (hs_idx % 128 == 0 && hs_idx > 0) check("layer_start_inflight", m_inf, 0);
                if (hs_idx == 3 * 128 + 34) begin
                    check("l3_left", int'(bus.left_idx_o), 66);
                    check("l3_right", int'(bus.right_idx_o), 82);
                    check("l3_zeta", int'(bus.zeta_addr_o), 10);
                end
                hs_idx++;
                due.push_back(cyc + lat);
            end
            if (prev_stall && bus.bf_valid) begin
                check("stall_hold_left", int'(bus.left_idx_o), int'(held_l));
                check("stall_hold_right", int'(bus.right_idx_o), int'(held_r));
                check("stall_hold_zeta", int'(bus.zeta_addr_o), int'(held_z));
            end
            prev_stall = bus.bf_valid && !bus.bf_ready;
            held_l = bus.left_idx_o;
            held_r = bus.right_idx_o;
            held_z = bus.zeta_addr_o;
            if (hs && !bus.out_valid_i) m_inf++;
            else if (!hs && bus.out_valid_i && m_inf > 0) m_inf--;
            if (done) done_cnt++;
            if (aborted) abort_cnt++;
        end
    end

    task automatic begin_run(output int s);
        load_expected();
        hs_idx = 0;
        @(negedge clk);
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_full(input int mode, input int l, input int exp_cyc);
        int s, t, dc, d0, a0;
        ready_mode = mode;
        lat = l;
        d0 = done_cnt;
        a0 = abort_cnt;
        begin_run(s);
        repeat (50) @(negedge clk);
        check("busy_mid_run", int'(busy), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!done && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20000) fail_now("done_timeout");
        dc = cyc;
        if (exp_cyc >= 0) check("done_cycle", dc - s, exp_cyc);
        check("handshake_count", hs_idx, 896);
        check("scoreboard_empty", sb.size(), 0);
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
        check("cycles_o", int'(cycles), dc - s);
        check("busy_after_done", int'(busy), 0);
        check("done_pulses", done_cnt - d0, 1);
        check("no_abort_pulse", abort_cnt - a0, 0);
    endtask

    task automatic run_abort();
        int s, t, c, ca, d0, a0;
        ready_mode = 0;
        lat = 4;
        d0 = done_cnt;
        a0 = abort_cnt;
        begin_run(s);
        t = 0;
        while (!(bus.bf_valid && layer == 3'd2 && bus.left_idx_o == 8'd82) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) fail_now("abort_point_timeout");
        abort = 1'b1;
        c = cyc;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid_low", int'(bus.bf_valid), 0);
        check("abort_busy", int'(busy), 1);
        sb.delete();
        t = 0;
        while (!aborted && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) fail_now("aborted_timeout");
        ca = cyc;
        check("aborted_cycle", ca - c, lat + 1);
        check("abort_handshakes", hs_idx, 2 * 128 + 51);
        @(negedge clk);
        check("aborted_one_cycle", int'(aborted), 0);
        check("busy_after_abort", int'(busy), 0);
        check("abort_cycles_o", int'(cycles), ca - s);
        check("abort_pulses", abort_cnt - a0, 1);
        check("abort_no_done", done_cnt - d0, 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_aborted"}, int'(aborted), 0);
        check({tag, "_bf_valid"}, int'(bus.bf_valid), 0);
        check({tag, "_left"}, int'(bus.left_idx_o), 0);
        check({tag, "_right"}, int'(bus.right_idx_o), 0);
        check({tag, "_zeta"}, int'(bus.zeta_addr_o), 0);
        check({tag, "_layer"}, int'(layer), 0);
        check({tag, "_cycles"}, int'(cycles), 0);
        check({tag, "_twiddle"}, int'(bus.twiddle_o), int'(rom(7'd0)));
    endtask

    task automatic run_reset();
        int s, t, d0, a0;
        ready_mode = 0;
        lat = 4;
        begin_run(s);
        t = 0;
        while (!(bus.bf_valid && layer == 3'd1) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) fail_now("reset_point_timeout");
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("mid_reset");
        sb.delete();
        due.delete();
        m_inf = 0;
        d0 = done_cnt;
        a0 = abort_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("post_reset_no_done", done_cnt - d0, 0);
        check("post_reset_no_abort", abort_cnt - a0, 0);
        check("post_reset_idle", int'(busy), 0);
    endtask

    initial begin
        bus.bf_ready    = 1'b0;
        bus.out_valid_i = 1'b0;
        #3 check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_full(0, 4, 932);
        run_full(1, 4, -1);
        run_full(2, int'($urandom_range(1, 8)), -1);
        run_full(0, 20, 7 * (128 + 21) + 1);
        run_abort();
        run_full(0, 4, 932);
        run_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
